// File: rtl/register_file_mp.sv
// Multi-port register file with write-to-read bypass, optional zero register
// and a per-register pending scoreboard for destination reservation.
module register_file_mp #(
   parameter int unsigned REG_SIZE = 32,
   parameter int unsigned REG_NUM  = 32,
   parameter int unsigned RD_PORTS = 2,
   parameter int unsigned WR_PORTS = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [WR_PORTS-1:0]                   wr_ena,
   input  logic [WR_PORTS*$clog2(REG_NUM)-1:0]   wr_addr,
   input  logic [WR_PORTS*REG_SIZE-1:0]          wr_data,
   input  logic [RD_PORTS*$clog2(REG_NUM)-1:0]   rd_addr,
   output logic [RD_PORTS*REG_SIZE-1:0]          rd_data,
   output logic [RD_PORTS-1:0]                   rd_pending,
   input  logic                                  rsv_ena,
   input  logic [$clog2(REG_NUM)-1:0]            rsv_addr,
   output logic                                  wr_conflict,
   output logic [$clog2(REG_NUM+1)-1:0]          pending_count
);

   localparam int unsigned AW = $clog2(REG_NUM);
   localparam int unsigned CW = $clog2(REG_NUM + 1);

   logic [REG_SIZE-1:0] regs [REG_NUM];
   logic [REG_NUM-1:0]  pending;
   logic [REG_NUM-1:0]  pending_nxt;
   logic [WR_PORTS-1:0] wr_eff;
   logic                rsv_eff;
   logic                conflict_nxt;
   logic [CW-1:0]       count_nxt;

   // Writes and reserves aimed at the hardwired zero register are dropped.
   always_comb begin
      wr_eff = '0;
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
         wr_eff[k] = wr_ena[k] &&
                     !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0));
      end
      rsv_eff = rsv_ena && !((ZERO_REG != 0) && (rsv_addr == '0));
   end

   // Scoreboard next state: writes clear, then a reserve sets (reserve wins).
   always_comb begin
      pending_nxt  = pending;
      conflict_nxt = 1'b0;
      count_nxt    = '0;
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
         if (wr_eff[k]) begin
            pending_nxt[wr_addr[k*AW +: AW]] = 1'b0;
         end
      end
      if (rsv_eff) begin
         pending_nxt[rsv_addr] = 1'b1;
      end
      for (int unsigned i = 0; i < WR_PORTS; i++) begin
         for (int unsigned j = i + 1; j < WR_PORTS; j++) begin
            if (wr_eff[i] && wr_eff[j] &&
                (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
               conflict_nxt = 1'b1;
            end
         end
      end
      for (int unsigned r = 0; r < REG_NUM; r++) begin
         count_nxt = count_nxt + CW'(pending_nxt[r]);
      end
   end

   // Later ports are assigned last, so the highest-index port wins a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < REG_NUM; r++) begin
            regs[r] <= '0;
         end
         pending       <= '0;
         wr_conflict   <= 1'b0;
         pending_count <= '0;
      end else begin
         for (int unsigned k = 0; k < WR_PORTS; k++) begin
            if (wr_eff[k]) begin
               regs[wr_addr[k*AW +: AW]] <= wr_data[k*REG_SIZE +: REG_SIZE];
            end
         end
         pending       <= pending_nxt;
         wr_conflict   <= conflict_nxt;
         pending_count <= count_nxt;
      end
   end

   // Combinational read ports with optional same-cycle forwarding.
   always_comb begin
      logic [AW-1:0]       ra;
      logic [REG_SIZE-1:0] d;
      logic                p;
      logic                hit;
      ra         = '0;
      d          = '0;
      p          = 1'b0;
      hit        = 1'b0;
      rd_data    = '0;
      rd_pending = '0;
      for (int unsigned j = 0; j < RD_PORTS; j++) begin
         ra  = rd_addr[j*AW +: AW];
         d   = regs[ra];
         p   = pending[ra];
         hit = 1'b0;
         if (BYPASS != 0) begin
            for (int unsigned k = 0; k < WR_PORTS; k++) begin
               if (wr_eff[k] && (wr_addr[k*AW +: AW] == ra)) begin
                  d   = wr_data[k*REG_SIZE +: REG_SIZE];
                  hit = 1'b1;
               end
            end
         end
         if (hit) begin
            p = rsv_eff && (rsv_addr == ra);
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            d = '0;
            p = 1'b0;
         end
         rd_data[j*REG_SIZE +: REG_SIZE] = d;
         rd_pending[j]                   = p;
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios then random
// traffic, with bypass and non-bypass instances checked against one model.
module tb_register_file_mp;

   logic        clk;
   logic        rst;
   logic [1:0]  wr_ena;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic        rsv_ena;
   logic [4:0]  rsv_addr;

   logic [63:0] rd_data_b,  rd_data_n;
   logic [1:0]  rd_pend_b,  rd_pend_n;
   logic        conf_b,     conf_n;
   logic [5:0]  cnt_b,      cnt_n;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_pend;

   register_file_mp #(.BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_pending(rd_pend_b), .rsv_ena(rsv_ena), .rsv_addr(rsv_addr),
      .wr_conflict(conf_b), .pending_count(cnt_b)
   );

   register_file_mp #(.BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_n),
      .rd_pending(rd_pend_n), .rsv_ena(rsv_ena), .rsv_addr(rsv_addr),
      .wr_conflict(conf_n), .pending_count(cnt_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_pend = '0;
   endtask

   // Expected read: the highest-index live write to the address wins when forwarding.
   task automatic exp_read(input int j, input bit byp, output logic [31:0] d, output logic p);
      logic [4:0] a;
      logic [4:0] wa;
      a = rd_addr[j*5 +: 5];
      d = m_regs[a];
      p = m_pend[a];
      if (byp) begin
         for (int k = 1; k >= 0; k--) begin
            wa = wr_addr[k*5 +: 5];
            if (wr_ena[k] && wa != 5'd0 && wa == a) begin
               d = wr_data[k*32 +: 32];
               p = rsv_ena && (rsv_addr == a);
               break;
            end
         end
      end
      if (a == 5'd0) begin
         d = '0;
         p = 1'b0;
      end
   endtask

   // One clock: drive, check reads mid-cycle, advance model, check registered outputs.
   task automatic cyc(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic rsv, input logic [4:0] rsa);
      logic [31:0] d;
      logic        p;
      logic        e_conf;
      logic [5:0]  e_cnt;
      logic [4:0]  wa;
      wr_ena = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
      rd_addr = {ra1, ra0}; rsv_ena = rsv; rsv_addr = rsa;
      #2;
      for (int j = 0; j < 2; j++) begin
         exp_read(j, 1'b1, d, p);
         chk("rd_data_bypass", rd_data_b[j*32 +: 32], d);
         chk("rd_pending_bypass", 32'(rd_pend_b[j]), 32'(p));
         exp_read(j, 1'b0, d, p);
         chk("rd_data_nobypass", rd_data_n[j*32 +: 32], d);
         chk("rd_pending_nobypass", 32'(rd_pend_n[j]), 32'(p));
      end
      e_conf = we[0] && we[1] && (wa0 == wa1) && (wa0 != 5'd0);
      for (int k = 0; k < 2; k++) begin
         wa = wr_addr[k*5 +: 5];
         if (we[k] && wa != 5'd0) begin
            m_regs[wa] = wr_data[k*32 +: 32];
            m_pend[wa] = 1'b0;
         end
      end
      if (rsv && rsa != 5'd0) m_pend[rsa] = 1'b1;
      e_cnt = 6'($countones(m_pend));
      @(posedge clk);
      #1;
      chk("wr_conflict_bypass", 32'(conf_b), 32'(e_conf));
      chk("wr_conflict_nobypass", 32'(conf_n), 32'(e_conf));
      chk("pending_count_bypass", 32'(cnt_b), 32'(e_cnt));
      chk("pending_count_nobypass", 32'(cnt_n), 32'(e_cnt));
   endtask

   initial begin
      rst = 1'b1; wr_ena = '0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; rsv_ena = 1'b0; rsv_addr = '0;
      model_clear();
      @(posedge clk); #1;
      chk("reset_count", 32'(cnt_b), 32'd0);
      chk("reset_conflict", 32'(conf_b), 32'd0);
      rst = 1'b0;

      // Write r5 with a reserve pending, then reset mid-cycle.
      cyc(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 5'd5);
      wr_ena = '0; rsv_ena = 1'b0; rd_addr = {5'd5, 5'd5};
      #2;
      chk("pre_reset_r5", rd_data_b[31:0], 32'hDEADBEEF);
      rst = 1'b1;
      #1;
      model_clear();
      chk("reset_r5_bypass", rd_data_b[31:0], 32'd0);
      chk("reset_r5_nobypass", rd_data_n[63:32], 32'd0);
      chk("reset_mid_count", 32'(cnt_b), 32'd0);
      chk("reset_mid_conflict", 32'(conf_b), 32'd0);
      chk("reset_mid_pending", 32'(rd_pend_b), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic dual write.
      cyc(2'b11, 5'd3, 32'h11, 5'd7, 32'h22, 5'd3, 5'd7, 1'b0, 5'd0);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd7, 1'b0, 5'd0);
      // Collision: port1 wins, conflict for one cycle only.
      cyc(2'b11, 5'd9, 32'hAAAA, 5'd9, 32'h5555, 5'd9, 5'd9, 1'b0, 5'd0);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd3, 1'b0, 5'd0);
      // Bypass versus pre-edge read.
      cyc(2'b10, 5'd0, 32'd0, 5'd4, 32'h0BAD, 5'd1, 5'd2, 1'b0, 5'd0);
      cyc(2'b01, 5'd4, 32'h1234, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0, 5'd0);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0, 5'd0);
      // Scoreboard: reserve, release by write, reserve+write same edge.
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 5'd6, 1'b1, 5'd6);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 5'd6, 1'b1, 5'd6);
      cyc(2'b01, 5'd6, 32'h66, 5'd0, 32'd0, 5'd6, 5'd6, 1'b0, 5'd0);
      cyc(2'b10, 5'd0, 32'd0, 5'd6, 32'h77, 5'd6, 5'd6, 1'b1, 5'd6);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 5'd6, 1'b0, 5'd0);
      // Zero register: writes, reserve and collision on r0 all ignored.
      cyc(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0);
      cyc(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd6, 1'b0, 5'd0);

      // Random traffic on a small address window to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         cyc(2'($urandom_range(0, 3)),
             5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
